// File: rtl/nios_128k_extended_keys.sv
// nios_128k_extended_keys
// -----------------------------------------------------------------------------
// Avalon-MM slave input port for the pushbutton keys. Each of the WIDTH
// asynchronous key inputs is passed through a two-flop synchroniser and then
// debounced: a new level is accepted only after it has been held for
// DEBOUNCE_CYCLES consecutive clocks. Transitions of the debounced level
// (selected by EDGE_TYPE) latch into a write-1-to-clear capture register,
// and any captured bit that is also enabled in irq_mask raises irq.
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   reset       synchronous, active-high reset
//   address     word select: 0 data, 1 reserved, 2 irq_mask, 3 edge_capture
//   chipselect  slave select, qualifies write_n
//   write_n     active-low write strobe
//   writedata   write data (only bits [WIDTH-1:0] are stored)
//   in_port     asynchronous key inputs (keys are active-low)
//   readdata    registered, zero-extended read data (1-cycle latency)
//   irq         level interrupt: |(edge_capture & irq_mask)
//
// Bus timing: there is no handshake and no wait state. A write is taken on
// the rising edge where chipselect is high and write_n is low. readdata is
// reloaded from the address-selected register every cycle regardless of
// chipselect, so a read returns the value that register held before the
// edge that loads readdata.
// -----------------------------------------------------------------------------
module nios_128k_extended_keys #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on the cycle before the new level would be accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            deb_q, deb_d;
  logic [WIDTH-1:0]            deb_dly_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            mask_q, mask_d;
  logic [WIDTH-1:0]            cap_q, cap_d;
  logic [31:0]                 readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] detect;

  assign wr_en = chipselect && !write_n;

  // Per-bit debounce. The counter only runs while the synchronised input
  // disagrees with the accepted level; any return to agreement clears it,
  // so a glitch shorter than DEBOUNCE_CYCLES leaves no trace. The counter
  // is cleared on acceptance, so it never goes past CNT_LAST and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge detect against the one-cycle-delayed debounced level.
  always_comb begin
    detect = deb_dly_q & ~deb_q;
    if (EDGE_TYPE == 1) begin
      detect = ~deb_dly_q & deb_q;
    end else if (EDGE_TYPE == 2) begin
      detect = deb_dly_q ^ deb_q;
    end
  end

  // Register writes. Detect is OR-ed in after the clear, so an edge that
  // lands on the same cycle as a clearing write is not lost.
  always_comb begin
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr_bits) | detect;
  end

  // Read mux, zero-extended; the reserved word always reads 0.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= IDLE_VALUE;
      sync2_q    <= IDLE_VALUE;
      deb_q      <= IDLE_VALUE;
      deb_dly_q  <= IDLE_VALUE;
      cnt_q      <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

  // Upper write-data bits have no storage behind them.
  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = |writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_nios_128k_extended_keys.sv
module tb_nios_128k_extended_keys;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  nios_128k_extended_keys #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (0),
    .IDLE_VALUE     (4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    address    = a;
    chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
    check(name, readdata, exp);
  endtask

  initial begin
    // Register-access vectors, in_port held idle. Each vector's readdata is
    // the selected register's value before that edge's write.
    vecs[0]  = '{"rd_data",       2'd0, 1'b1, 1'b1, 32'h0,        32'hF, 1'b0};
    vecs[1]  = '{"rd_reserved",   2'd1, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[2]  = '{"rd_mask",       2'd2, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[3]  = '{"rd_capture",    2'd3, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[4]  = '{"wr_mask",       2'd2, 1'b1, 1'b0, 32'hFFFFFFF5, 32'h0, 1'b0};
    vecs[5]  = '{"rd_mask_5",     2'd2, 1'b1, 1'b1, 32'h0,        32'h5, 1'b0};
    vecs[6]  = '{"wr_data_ign",   2'd0, 1'b1, 1'b0, 32'h0,        32'hF, 1'b0};
    vecs[7]  = '{"rd_data_keep",  2'd0, 1'b1, 1'b1, 32'h0,        32'hF, 1'b0};
    vecs[8]  = '{"wr_resv_ign",   2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[9]  = '{"rd_resv_keep",  2'd1, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
    vecs[10] = '{"wr_nocs",       2'd2, 1'b0, 1'b0, 32'h0,        32'h5, 1'b0};
    vecs[11] = '{"rd_nocs_keep",  2'd2, 1'b1, 1'b1, 32'h0,        32'h5, 1'b0};
    vecs[12] = '{"wr_nostrobe",   2'd2, 1'b1, 1'b1, 32'h0,        32'h5, 1'b0};
    vecs[13] = '{"rd_nostb_keep", 2'd2, 1'b1, 1'b1, 32'h0,        32'h5, 1'b0};
    vecs[14] = '{"wr_mask_0",     2'd2, 1'b1, 1'b0, 32'h0,        32'h5, 1'b0};
    vecs[15] = '{"rd_mask_0",     2'd2, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};

    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    ticks(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // Table-driven register access, scoreboarded through exp_q
    foreach (vecs[k]) begin
      address    = vecs[k].addr;
      chipselect = vecs[k].cs;
      write_n    = vecs[k].wr_n;
      writedata  = vecs[k].wdata;
      exp_q.push_back(vecs[k].exp_rd);
      exp_q.push_back({31'b0, vecs[k].exp_irq});
      tick();
      check(vecs[k].name, readdata, exp_q.pop_front());
      check({vecs[k].name, "_irq"}, {31'b0, irq}, exp_q.pop_front());
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Press bit0 with mask 0: debounce latency, capture, no irq
    address = 2'd0;
    in_port = 4'hE;
    ticks(6);
    check("deb_lat_t6", readdata, 32'hF);
    tick();
    check("deb_lat_t7", readdata, 32'hE);
    check("irq_masked_off", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h1, "cap_bit0");
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 32'h0, "cap_bit0_clr");
    in_port = 4'hF;
    ticks(8);
    bus_read(2'd3, 32'h0, "rise_ignored");
    bus_read(2'd0, 32'hF, "data_released");

    // Mask bit0, press: irq follows capture, clears the cycle after W1C
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    in_port = 4'hE;
    ticks(6);
    check("irq_before_cap", {31'b0, irq}, 32'h0);
    tick();
    check("irq_with_cap", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_after_clr", {31'b0, irq}, 32'h0);
    bus_read(2'd3, 32'h0, "cap_after_clr");
    in_port = 4'hF;
    ticks(8);
    check("irq_after_release", {31'b0, irq}, 32'h0);

    // Bit1 glitch of 3 cycles is rejected; exactly 4 cycles is accepted
    in_port = 4'hD;
    ticks(3);
    in_port = 4'hF;
    ticks(10);
    bus_read(2'd0, 32'hF, "glitch3_data");
    bus_read(2'd3, 32'h0, "glitch3_cap");
    in_port = 4'hD;
    ticks(4);
    in_port = 4'hF;
    ticks(10);
    bus_read(2'd3, 32'h2, "pulse4_cap");
    check("pulse4_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, 32'h0, "pulse4_clr");

    // Bit2 detect on the same edge as a W1C of bit2: bit stays set
    in_port = 4'hB;
    ticks(6);
    address    = 2'd3;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h4;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    check("bit2_irq_masked", {31'b0, irq}, 32'h0);
    tick();
    check("clr_vs_detect", readdata, 32'h4);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, 32'h0, "bit2_later_clr");
    in_port = 4'hF;
    ticks(8);
    bus_read(2'd3, 32'h0, "bit2_release");

    // Bit3 press captures, release does not
    in_port = 4'h7;
    ticks(8);
    bus_read(2'd3, 32'h8, "bit3_press");
    bus_write(2'd3, 32'h8);
    in_port = 4'hF;
    ticks(8);
    bus_read(2'd3, 32'h0, "bit3_release");

    // Reset with irq pending, no capture after release
    address = 2'd0;
    in_port = 4'hE;
    ticks(7);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    reset   = 1'b1;
    in_port = 4'hF;
    tick();
    check("mid_reset_irq", {31'b0, irq}, 32'h0);
    check("mid_reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    ticks(10);
    check("post_reset_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd0, 32'hF, "post_reset_data");
    bus_read(2'd2, 32'h0, "post_reset_mask");
    bus_read(2'd3, 32'h0, "post_reset_cap");

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_128k_extended_keys.md
Name: nios_128k_extended_keys

Overview:
- Avalon-MM slave input port for the pushbutton keys. It is the read-side counterpart of the seven-segment output ports.
- Synchronises and debounces WIDTH external inputs and presents the debounced level to the Nios II.
- Latches per-bit edge events into a capture register and raises a maskable interrupt.
- Sits on the system interconnect beside the hex output ports.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive clk cycles an input must hold a new level before it is accepted (>=1).
- EDGE_TYPE, 0, which debounced transition sets a capture bit: 0 = falling, 1 = rising, 2 = any.
- IDLE_VALUE, all ones (WIDTH bits), reset value of the synchronisers and the debounced register.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  2  register word select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous key inputs (active-low keys).
- readdata  output  32  registered read data, zero-extended.
- irq  output  1  level interrupt request to the CPU.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - sync stages = IDLE_VALUE
  - debounced = IDLE_VALUE
  - debounced_d = IDLE_VALUE
  - debounce counters = 0
  - irq_mask = 0
  - edge_capture = 0
  - readdata = 0
  - irq = 0 (since mask = 0)
- Synchroniser: two flops per bit. in_port reaches sync2 two cycles after it changes.
- Debounce, per bit, with an independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == debounced, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, debounced takes sync2 and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES returns the counter to 0 and is ignored.
  - The counter never wraps.
- Latency: a clean input step appears in debounced DEBOUNCE_CYCLES+2 cycles after in_port changes.
- Edge detect: debounced_d <= debounced each cycle. A detect pulse is generated per EDGE_TYPE:
  - falling: debounced_d & ~debounced
  - rising: ~debounced_d & debounced
  - any: XOR of the two
- Register map (word addresses):
  - 0 data: read-only, returns debounced. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irq_mask: read/write, bits [WIDTH-1:0].
  - 3 edge_capture: read returns capture bits. A write clears each bit where writedata is 1 (write-1-to-clear).
- Write accepted when chipselect && !write_n; the register updates on that edge. No wait states.
- edge_capture update: new = (old & ~clear) | detect. A simultaneous clear and detect on the same bit leaves the bit set.
- irq = |(edge_capture & irq_mask). It is combinational from registers, stays asserted until the bits are cleared or masked, and goes low the cycle after the clearing write.
- readdata <= zero-extended mux(address) every cycle, independent of chipselect. Read latency is 1 cycle. Upper 32-WIDTH bits are always 0.
- Reset asserted mid-debounce or with irq pending: all state returns to reset values on that edge. No spurious edge is generated on release, because debounced and debounced_d both equal IDLE_VALUE.
- Inputs held at IDLE_VALUE never produce a capture.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, IDLE_VALUE=4'hF):
- Reset, then read address 0 -> readdata 0x0000000F. Reads of 1, 2, 3 -> 0. irq = 0.
- in_port 4'hF->4'hE held at cycle t -> debounced bit0 = 0 at t+6, edge_capture = 0x1 at t+7, read address 0 returns 0xE and address 3 returns 0x1. irq stays 0 while mask = 0.
- Write irq_mask = 0x1, then press bit0 -> irq rises together with edge_capture[0]. Write 0x1 to address 3 -> irq falls the next cycle and edge_capture reads 0.
- Bit1 pulsed low for 3 cycles, then high -> debounced unchanged (0xF), edge_capture stays 0, counter returns to 0.
- Bit2 detect pulse on the same edge as a write of 0x4 to address 3 -> edge_capture[2] remains 1. A write of 0x4 on a later cycle clears it.
- Bit3 released low->high with EDGE_TYPE=0 -> no capture. Assert reset while bit0 is pending with irq high -> irq = 0 and all registers at reset values the next cycle. No capture appears after reset release.
